// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a main output register
// backed by a one-entry skid register, so in_ready stays a registered signal.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] FMT_NONE  = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_ZIMM  = 3'd6;
    localparam logic [2:0] FMT_SHAMT = 3'd7;

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_s;
    logic [5:0]      w_shamt;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_fmt;
    logic            w_ill;
    logic            w_accept;
    logic            w_main_load;

    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;
    logic             r_main_ill;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;
    logic             r_skid_ill;
    logic [TAG_W-1:0] r_skid_tag;

    assign w_opc   = in_inst[6:0];
    assign w_f3    = in_inst[14:12];
    assign w_s     = in_inst[31];
    // RV32 has a 5-bit shamt; bit 25 is then reserved and flagged illegal.
    assign w_shamt = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

    always_comb begin
        w_imm = '0;
        w_fmt = FMT_NONE;
        w_ill = 1'b0;
        case (w_opc)
            7'b0000011, 7'b1100111: begin
                w_imm = {{(XLEN-11){w_s}}, in_inst[30:20]};
                w_fmt = FMT_I;
            end
            7'b0010011: begin
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_imm = {{(XLEN-6){1'b0}}, w_shamt};
                    w_fmt = FMT_SHAMT;
                    w_ill = (XLEN == 32) && in_inst[25];
                end else begin
                    w_imm = {{(XLEN-11){w_s}}, in_inst[30:20]};
                    w_fmt = FMT_I;
                end
            end
            7'b0100011: begin
                w_imm = {{(XLEN-11){w_s}}, in_inst[30:25], in_inst[11:7]};
                w_fmt = FMT_S;
            end
            7'b1100011: begin
                w_imm = {{(XLEN-12){w_s}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                w_fmt = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
                w_imm = {{(XLEN-31){w_s}}, in_inst[30:12], 12'b0};
                w_fmt = FMT_U;
            end
            7'b1101111: begin
                w_imm = {{(XLEN-20){w_s}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                w_fmt = FMT_J;
            end
            7'b1110011: begin
                if (w_f3[2]) begin
                    w_imm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
                    w_fmt = FMT_ZIMM;
                end
            end
            7'b0110011, 7'b0001111: begin
                w_fmt = FMT_NONE;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    assign in_ready    = ~r_skid_valid;
    assign w_accept    = in_valid & ~r_skid_valid;
    assign w_main_load = ~r_main_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_fmt   <= FMT_NONE;
            r_main_ill   <= 1'b0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FMT_NONE;
            r_skid_ill   <= 1'b0;
            r_skid_tag   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_load) begin
            // A valid skid entry is older than anything on the input.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_main_ill   <= r_skid_ill;
                r_main_tag   <= r_skid_tag;
                r_skid_valid <= 1'b0;
            end else begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_imm <= w_imm;
                    r_main_fmt <= w_fmt;
                    r_main_ill <= w_ill;
                    r_main_tag <= in_tag;
                end
            end
        end else if (w_accept) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_imm;
            r_skid_fmt   <= w_fmt;
            r_skid_ill   <= w_ill;
            r_skid_tag   <= in_tag;
        end
    end

    assign out_valid   = r_main_valid;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_fmt;
    assign out_illegal = r_main_ill;
    assign out_tag     = r_main_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: an XLEN=32 and an XLEN=64 instance share
// clock, flush and out_ready; a select picks which one receives input words.
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
        logic        full;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b1;

    logic        rdy_a, val_a, ill_a;
    logic [31:0] imm_a, tag_a;
    logic [2:0]  fmt_a;
    logic        rdy_b, val_b, ill_b;
    logic [63:0] imm_b;
    logic [31:0] tag_b;
    logic [2:0]  fmt_b;

    int total = 0;
    int bad = 0;
    int tag_cnt = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & ~sel), .in_ready(rdy_a),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(val_a), .out_ready(out_ready),
        .out_imm(imm_a), .out_fmt(fmt_a), .out_illegal(ill_a), .out_tag(tag_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & sel), .in_ready(rdy_b),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(val_b), .out_ready(out_ready),
        .out_imm(imm_b), .out_fmt(fmt_b), .out_illegal(ill_b), .out_tag(tag_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitors: an output transfers on the coming edge when valid & ready.
    always @(negedge clk) begin
        if (!rst && !flush && val_a && out_ready) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL x32 unexpected output: imm=0x%0h tag=0x%0h", imm_a, tag_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                if (ill_a !== e.ill || tag_a !== e.tag ||
                    (e.full && (imm_a !== e.imm[31:0] || fmt_a !== e.fmt))) begin
                    bad++;
                    $display("FAIL x32 out: got imm=0x%0h fmt=%0d ill=%0b tag=0x%0h expected imm=0x%0h fmt=%0d ill=%0b tag=0x%0h",
                             imm_a, fmt_a, ill_a, tag_a, e.imm[31:0], e.fmt, e.ill, e.tag);
                end else begin
                    $display("ok   x32 out imm=0x%0h fmt=%0d ill=%0b tag=0x%0h", imm_a, fmt_a, ill_a, tag_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && !flush && val_b && out_ready) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL x64 unexpected output: imm=0x%0h tag=0x%0h", imm_b, tag_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                if (ill_b !== e.ill || tag_b !== e.tag ||
                    (e.full && (imm_b !== e.imm || fmt_b !== e.fmt))) begin
                    bad++;
                    $display("FAIL x64 out: got imm=0x%0h fmt=%0d ill=%0b tag=0x%0h expected imm=0x%0h fmt=%0d ill=%0b tag=0x%0h",
                             imm_b, fmt_b, ill_b, tag_b, e.imm, e.fmt, e.ill, e.tag);
                end else begin
                    $display("ok   x64 out imm=0x%0h fmt=%0d ill=%0b tag=0x%0h", imm_b, fmt_b, ill_b, tag_b);
                end
            end
        end
    end

    // Offer one word to the selected instance; expectation is queued at the
    // negedge before the accepting edge.
    task automatic send(input logic s, input logic [31:0] inst, input logic [63:0] imm,
                        input logic [2:0] fmt, input logic ill, input logic full);
        exp_t e;
        bit   done;
        done = 1'b0;
        tag_cnt++;
        sel      = s;
        in_inst  = inst;
        in_tag   = 32'hC000_0000 + tag_cnt;
        in_valid = 1'b1;
        e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = in_tag; e.full = full;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if ((s ? rdy_b : rdy_a) === 1'b1) begin
                if (s) q_b.push_back(e); else q_a.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL send timeout: inst=0x%0h never accepted", inst);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready32", {63'd0, rdy_a}, 64'd1);
        chk("rst out_valid32", {63'd0, val_a}, 64'd0);
        chk("rst out_imm32", {32'd0, imm_a}, 64'd0);
        chk("rst out_fmt32", {61'd0, fmt_a}, 64'd0);
        chk("rst out_ill32", {63'd0, ill_a}, 64'd0);
        chk("rst out_tag32", {32'd0, tag_a}, 64'd0);
        chk("rst in_ready64", {63'd0, rdy_b}, 64'd1);
        chk("rst out_imm64", imm_b, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single words, XLEN=32
        send(0, 32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 0, 1);
        @(negedge clk);
        chk("latency out_valid", {63'd0, val_a}, 64'd1);
        @(posedge clk); #1;
        send(0, 32'hFE112E23, 64'hFFFF_FFFC, 3'd2, 0, 1);
        send(0, 32'h123452B7, 64'h1234_5000, 3'd4, 0, 1);
        send(0, 32'h800002B7, 64'h8000_0000, 3'd4, 0, 1);
        send(0, 32'h00001097, 64'h0000_1000, 3'd4, 0, 1);
        send(0, 32'hFF9FF06F, 64'hFFFF_FFF8, 3'd5, 0, 1);
        send(0, 32'hFE000EE3, 64'hFFFF_FFFC, 3'd3, 0, 1);
        send(0, 32'hFFC12083, 64'hFFFF_FFFC, 3'd1, 0, 1);
        send(0, 32'h4030D093, 64'h0000_0003, 3'd7, 0, 1);
        send(0, 32'h02309093, 64'h0000_0000, 3'd7, 1, 0);
        send(0, 32'h3402D073, 64'h0000_0005, 3'd6, 0, 1);
        send(0, 32'h34011073, 64'h0000_0000, 3'd0, 0, 1);
        send(0, 32'h00B50533, 64'h0000_0000, 3'd0, 0, 1);
        send(0, 32'h0000000F, 64'h0000_0000, 3'd0, 0, 1);
        send(0, 32'h00000000, 64'h0000_0000, 3'd0, 1, 1);
        send(0, 32'hFFF00090, 64'h0000_0000, 3'd0, 1, 1);

        // XLEN=64
        send(1, 32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 0, 1);
        send(1, 32'h03F09093, 64'h0000_0000_0000_003F, 3'd7, 0, 1);
        send(1, 32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 0, 1);
        send(1, 32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 0, 1);
        repeat (3) @(posedge clk); #1;

        // Backpressure: third word held until the skid drains
        out_ready = 1'b0;
        fork
            begin
                send(0, 32'h00100093, 64'd1, 3'd1, 0, 1);
                send(0, 32'h00200093, 64'd2, 3'd1, 0, 1);
                send(0, 32'h00300093, 64'd3, 3'd1, 0, 1);
            end
            begin
                repeat (3) @(posedge clk); #1;
                chk("stall in_ready", {63'd0, rdy_a}, 64'd0);
                chk("stall out_valid", {63'd0, val_a}, 64'd1);
                chk("stall out_imm hold", {32'd0, imm_a}, 64'd1);
                out_ready = 1'b1;
                @(posedge clk); #1;
                chk("drain in_ready", {63'd0, rdy_a}, 64'd1);
            end
        join
        repeat (3) @(posedge clk); #1;

        // Flush with both entries full and a third word offered
        out_ready = 1'b0;
        send(0, 32'h00700093, 64'd7, 3'd1, 0, 1);
        send(0, 32'h00800093, 64'd8, 3'd1, 0, 1);
        in_inst = 32'h00900093; in_tag = 32'hDEAD_0009; sel = 1'b0;
        in_valid = 1'b1; flush = 1'b1;
        q_a.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush out_valid", {63'd0, val_a}, 64'd0);
        chk("flush in_ready", {63'd0, rdy_a}, 64'd1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        send(0, 32'h00A00093, 64'd10, 3'd1, 0, 1);
        repeat (2) @(posedge clk); #1;

        // Reset mid-stall discards both entries
        out_ready = 1'b0;
        send(0, 32'h00B00093, 64'd11, 3'd1, 0, 1);
        send(0, 32'h00C00093, 64'd12, 3'd1, 0, 1);
        rst = 1'b1; flush = 1'b1;
        q_a.delete();
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        chk("rst stall out_valid", {63'd0, val_a}, 64'd0);
        chk("rst stall in_ready", {63'd0, rdy_a}, 64'd1);
        chk("rst stall out_imm", {32'd0, imm_a}, 64'd0);
        out_ready = 1'b1;
        send(0, 32'hFFF00093, 64'hFFFF_FFFF, 3'd1, 0, 1);
        repeat (4) @(posedge clk); #1;

        chk("queue32 empty", 64'(q_a.size()), 64'd0);
        chk("queue64 empty", 64'(q_b.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. Accepts one instruction word per cycle over a valid/ready handshake and produces the fully sign- or zero-extended immediate for every RV32I/RV64I format: I, S, B, U, J, shift-amount and CSR zimm. Each result carries a format code, an illegal flag and a pass-through tag such as the PC. A two-entry output buffer (main plus skid register) keeps full throughput under backpressure; the block sits between fetch/IF-ID and the register-read/ALU operand mux.

## Interface
- XLEN, 32: immediate width; legal values are 32 and 64 only.
- TAG_W, 32: width of the opaque pass-through tag.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  drops all buffered entries; has priority over every other event.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  block can accept this cycle.
- in_inst  in  32  instruction word.
- in_tag  in  TAG_W  tag (PC), returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 ZIMM, 7 SHAMT.
- out_illegal  out  1  unsupported encoding.
- out_tag  out  TAG_W  tag of the presented result.

## Operation
- Decode is on opcode = inst[6:0] and f3 = inst[14:12]. All sign extension replicates inst[31] up to XLEN.
- 0000011 LOAD, 1100111 JALR, and 0010011 OP-IMM with f3 not in {001,101}: I-type, imm = sext(inst[31:20]).
- 0010011 with f3 in {001,101}: SHAMT, imm = zext(shamt).
  - XLEN=32: shamt = inst[24:20]; inst[25]=1 is illegal.
  - XLEN=64: shamt = inst[25:20].
  - Funct7 bits are never part of imm.
- 0100011 STORE: S-type, imm = sext({inst[31:25], inst[11:7]}).
- 1100011 BRANCH: B-type, imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- 0110111 LUI and 0010111 AUIPC: U-type, imm = sext({inst[31:12], 12'b0}).
- 1101111 JAL: J-type, imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- 1110011 SYSTEM:
  - f3[2]=1: ZIMM, imm = zext(inst[19:15]).
  - Otherwise: NONE, imm 0.
- 0110011 OP and 0001111 FENCE: NONE, imm 0, legal.
- Any other opcode, or inst[1:0] != 2'b11: NONE, imm 0, illegal=1. The illegal entry still flows through the buffer in order.
- Buffer:
  - The main register drives the out_* ports.
  - The skid register captures an accepted word while main is full and not draining.
  - Results leave in acceptance order.
- in_ready = !skid_valid. It is a registered signal and never combinationally depends on out_ready.

## Timing
- Reset: in_ready=1, out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0, skid empty.
- Latency: a word accepted in cycle N (in_valid & in_ready) is presented in cycle N+1. Throughput is 1 per cycle while out_ready=1.
- Main register loads when it is empty or out_ready=1. The source is the skid entry if one is valid, otherwise the input.
- Skid register loads when an input is accepted while main is valid and out_ready=0. in_ready drops in the following cycle.
- Skid drains into main on the first cycle out_ready=1. in_ready returns to 1 in the cycle after that.
- Simultaneous accept and drain with skid empty: main is replaced, no bubble.
- out_* hold stable while out_valid=1 and out_ready=0.
- flush in cycle N: out_valid=0 and skid empty in N+1, in_ready=1 in N+1. An input offered in N is discarded.
- rst overrides flush. Reset mid-stall discards both entries.

## Test plan
- Single words, XLEN=32, out_ready=1:
  - 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF, fmt 1, one cycle after accept.
  - 0xFE112E23 (sw x1,-4(x2)) -> 0xFFFFFFFC, fmt 2.
  - 0x123452B7 (lui) -> 0x12345000, fmt 4.
- Control flow:
  - 0xFF9FF06F (jal x0,-8) -> 0xFFFFFFF8, fmt 5.
  - 0xFE000EE3 (beq x0,x0,-4) -> 0xFFFFFFFC, fmt 3.
- Shifts and system:
  - 0x4030D093 (srai 3) -> imm 3, fmt 7.
  - 0x02309093 (XLEN=32, bit25 set) -> illegal=1.
  - 0x3402D073 (csrrwi) -> imm 5, fmt 6.
  - 0x00000000 -> illegal=1, imm 0.
- Backpressure:
  - Stream 0x00100093, 0x00200093, 0x00300093 with out_ready=0 -> first two accepted, in_ready=0 from the cycle after the second.
  - Raise out_ready -> outputs 1, 2, 3 in order, tags preserved, no duplicates.
- Flush: flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of those three words ever appear.
- XLEN=64 build:
  - 0xFFF00093 -> 0xFFFFFFFFFFFFFFFF.
  - 0x03F09093 -> shamt 63, legal.
  - 0x800002B7 -> 0xFFFFFFFF80000000.
